// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, reset PC, NOP encoding and the IF/ID bundle.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } ifid_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: async-reset register with load enable and a branch/sequential next-value mux.
module pc_register #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Branch targets are forced to word alignment; sequential fetch wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      if (branch_taken_i) begin
        pc_d = branch_addr_i & ~ADDR_W'(3);
      end else begin
        pc_d = pc_q + ADDR_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: drives the ROM address from the PC and captures the IF/ID register.
// Optional saturating fetch/stall counters are built when FETCH_PERF_CNT_EN is defined.
module inst_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [INST_W-1:0] ifid_inst,
  output logic              ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  import cpu_pkg::*;

  localparam int unsigned BUS_AW = $bits(ifid_t) - 1 - cpu_pkg::INST_W;
  localparam int unsigned BUS_IW = cpu_pkg::INST_W;

  logic              advance;
  logic              load_en;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  // Branch wins over freeze; freeze stalls everything; otherwise advance.
  assign advance  = ~branch_taken & ~freeze;
  assign load_en  = branch_taken | ~freeze;
  assign pc_plus4 = pc + ADDR_W'(PC_STEP);

  pc_register #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (ADDR_W'(PC_RESET))
  ) u_pc_register (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en_i      (load_en),
    .branch_taken_i (branch_taken),
    .branch_addr_i  (branch_addr),
    .pc_o           (pc)
  );

  assign rom_addr = pc;

  always_comb begin
    ifid_d = ifid_q;
    if (branch_taken) begin
      ifid_d.pc    = '0;
      ifid_d.inst  = NOP_INST;
      ifid_d.valid = 1'b0;
    end else if (!freeze) begin
      ifid_d.pc    = BUS_AW'(pc_plus4);
      ifid_d.inst  = BUS_IW'(rom_inst);
      ifid_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q.pc    <= '0;
      ifid_q.inst  <= NOP_INST;
      ifid_q.valid <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_pc    = ADDR_W'(ifid_q.pc);
  assign ifid_inst  = INST_W'(ifid_q.inst);
  assign ifid_valid = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic        stall;
  logic [31:0] fetch_cnt_d;
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;

  assign stall = freeze & ~branch_taken;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (advance && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed vector bench for inst_fetch_stage with a combinational ROM model.
module tb_inst_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_checks;
  int n_errors;

  inst_fetch_stage #(
    .PC_RESET (32'h0000_0000),
    .ADDR_W   (32),
    .INST_W   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst),
    .ifid_pc      (ifid_pc),
    .ifid_inst    (ifid_inst),
    .ifid_valid   (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  // ROM contents: word 0 is an all-zero NOP, word 1 a fixed pattern, others tagged by index.
  function automatic logic [31:0] rom_word(input logic [9:0] idx);
    if (idx == 10'd0) return 32'h0000_0000;
    if (idx == 10'd1) return 32'h8001_060A;
    return 32'hC0DE_0000 | {22'h0, idx};
  endfunction

  assign rom_inst = rom_word(rom_addr[11:2]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic e_valid);
    check({tag, ".rom_addr"}, rom_addr, e_addr);
    check({tag, ".ifid_inst"}, ifid_inst, e_inst);
    check({tag, ".ifid_pc"}, ifid_pc, e_pc);
    check({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, e_valid});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //          frz   br    baddr          rom_addr       ifid_inst      ifid_pc        valid
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0008, 32'h8001_060A, 32'h0000_0008, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0000_000C, 32'hC0DE_0002, 32'h0000_000C, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0010, 32'hC0DE_0003, 32'h0000_0010, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0010, 32'hC0DE_0003, 32'h0000_0010, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0010, 32'hC0DE_0003, 32'h0000_0010, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0010, 32'hC0DE_0003, 32'h0000_0010, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0014, 32'hC0DE_0004, 32'h0000_0014, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h50,       32'h0000_0050, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h8C,       32'h0000_008C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0000_0090, 32'hC0DE_0023, 32'h0000_0090, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h1B6,      32'h0000_01B4, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        32'h0000_01B4, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h1B8,      32'h0000_01B8, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h1B8,      32'h0000_01B8, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h1B8,      32'h0000_01B8, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        32'h0000_01BC, 32'hC0DE_006E, 32'h0000_01BC, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 32'hC0DE_03FF, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1};

    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_all("release", 32'h0, 32'h0, 32'h0, 1'b0);

    // Table-driven main sequence: inputs applied, one edge, outputs compared.
    for (int i = 0; i < NVEC; i++) begin
      freeze       = vecs[i].frz;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_valid);
    end

    // Fresh reset, then 5 fetches and 2 stalls for the counters.
    freeze       = 1'b0;
    branch_taken = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_all("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_all("five_fetch", 32'h14, 32'hC0DE_0004, 32'h14, 1'b1);
    freeze = 1'b1;
    step();
    step();
    check_all("two_stall", 32'h14, 32'hC0DE_0004, 32'h14, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'd5);
    check("stall_count", stall_count, 32'd2);
`endif

    // Move to pc 0x40, advance once, then pulse reset asynchronously mid-cycle.
    freeze       = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    step();
    check_all("to_40", 32'h40, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    step();
    check_all("from_40", 32'h44, 32'hC0DE_0010, 32'h44, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_rst", fetch_count, 32'd0);
    check("stall_count_rst", stall_count, 32'd0);
`endif
    step();
    check_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check_all("first_fetch", 32'h4, 32'h0, 32'h4, 1'b1);
    step();
    check_all("second_fetch", 32'h8, 32'h8001_060A, 32'h8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Pipeline front end and the initiator side of the instruction-memory read interface.
- Holds the PC and drives a word-aligned byte address to the combinational instruction ROM.
- Captures the returned instruction into the IF/ID pipeline register.
- Accepts freeze from the hazard unit and branch redirects from EX; a redirect squashes the wrong-path instruction by inserting a NOP.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- freeze  in  1  hazard stall; holds PC and IF/ID.
- branch_taken  in  1  EX-stage redirect request.
- branch_addr  in  ADDR_W  redirect target byte address.
- rom_addr  out  ADDR_W  byte address to instruction ROM (ROM indexes bits [11:2]).
- rom_inst  in  INST_W  combinational ROM read data for rom_addr.
- ifid_pc  out  ADDR_W  PC+4 of the captured instruction.
- ifid_inst  out  INST_W  captured instruction.
- ifid_valid  out  1  IF/ID holds a real (non-squashed) instruction.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc = PC_RESET, so rom_addr = PC_RESET.
  - ifid_pc = 0, ifid_inst = 32'h0 (NOP), ifid_valid = 0.
- Reset asserted mid-operation clears all state immediately; the first fetch is at PC_RESET on the first rising edge after deassertion.
- rom_addr = pc, driven combinationally from the PC register. Zero-cycle ROM read: rom_inst is sampled on the same edge that advances the PC.
- Fetch latency: an instruction at address A appears on ifid_inst one cycle after pc = A.
- Per-edge priority, highest first:
  1. branch_taken=1 (overrides freeze):
     - pc <= {branch_addr[31:2], 2'b00}; misaligned targets are silently aligned.
     - IF/ID loaded with NOP: inst = 0, pc = 0, valid = 0.
  2. freeze=1, branch_taken=0: pc, ifid_pc, ifid_inst and ifid_valid all hold.
  3. Otherwise:
     - pc <= pc + 4, wrapping modulo 2^ADDR_W; 32'hFFFF_FFFC goes to 0.
     - ifid_inst <= rom_inst, ifid_pc <= pc + 4 (same wrap), ifid_valid <= 1.
- A branch to its own address (a self-loop halt) repeats every cycle. Each iteration yields one NOP bubble in IF/ID while branch_taken is held.
- PC bits above [11] are not checked; the ROM aliases them.
- All-zero words from the ROM are passed through as valid NOPs. Only squash bubbles have ifid_valid = 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined — adds two 32-bit outputs, reset to 0, saturating at 32'hFFFF_FFFF:
  - fetch_count: increments on every normal-advance edge.
  - stall_count: increments on every edge with freeze=1 and branch_taken=0.
- Undefined — the ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - INST_W, ADDR_W, PC_RESET.
  - NOP_INST = 32'h0.
  - PC_STEP = 4.
  - Typedef for the IF/ID bundle {pc, inst, valid}.
- One natural sub-module: pc_register. It holds the PC with async reset, load-enable (not freeze, or branch) and next-value mux.
- The IF/ID register and the optional counters live in inst_fetch_stage.

Test Plan:
- Reset release with a ROM model (word 1 = 32'h8001_060A):
  - Cycle 0: rom_addr = 0.
  - Cycle 1: rom_addr = 4, ifid_inst = ROM[0], ifid_pc = 4, ifid_valid = 1.
  - Cycle 2: ifid_inst = 32'h8001_060A, ifid_pc = 8.
- freeze high for 3 cycles at pc = 16 -> rom_addr stays 16, IF/ID holds pc 16 and ROM[3] for 3 cycles, then resumes at 20.
- branch_taken with branch_addr = 0x8C at pc = 0x50 -> next rom_addr = 0x8C; IF/ID = NOP, valid = 0; the following cycle captures ROM[35] with ifid_pc = 0x90.
- branch_taken and freeze asserted together, branch_addr = 0x1B6 -> rom_addr = 0x1B4 (aligned), IF/ID squashed; freeze is ignored that cycle.
- Self-loop: branch_taken held with branch_addr = 0x1B8 -> rom_addr stays 0x1B8 every cycle and ifid_valid stays 0.
- rst_n pulsed low asynchronously mid-cycle at pc = 0x40 -> outputs clear immediately without a clock edge. With FETCH_PERF_CNT_EN defined, both counters read 0 after 5 fetches and 2 stalls once reset is applied.
